mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register plus writeback logic for the pipelined core; drives the register file write port.
//   Registers MEM-stage results, extracts and extends load data, selects the writeback result, and retires instructions.
//   Provides WB->ID bypass of register-file read data, because the register file writes on the clock edge while its reads are asynchronous.
//   Maintains the retired-instruction counter (instret).
// PARAMETERS
//   DATA_WIDTH     32  datapath width; only 32 supported
//   ADDRESS_WIDTH  5   register index width
//   INSTRET_WIDTH  64  retired-instruction counter width
// PORTS
//   clk            in   1   clock; all state updates on posedge
//   rst            in   1   synchronous reset, active-high
//   stall_w        in   1   hold WB register contents
//   flush_w        in   1   capture a bubble instead of the MEM instruction
//   valid_m        in   1   MEM stage holds a real instruction
//   reg_write_m    in   1   instruction writes rd
//   rd_m           in   5   destination register
//   result_src_m   in   2   00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
//   funct3_m       in   3   load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//   alu_result_m   in   32  ALU result, or load address
//   read_data_m    in   32  raw aligned word from data memory
//   pc_plus4_m     in   32  PC+4 for JAL/JALR
//   AD3            out  5   register file write address
//   WD3            out  32  register file write data
//   WE3            out  1   register file write enable
//   rs1_d, rs2_d   in   5   ID-stage source indices
//   rf_rd1, rf_rd2 in   32  raw register file read data (RD1/RD2)
//   rd1_d, rd2_d   out  32  bypassed operands to ID
//   instret        out  64  retired-instruction count
// BEHAVIOUR
//   - Register update priority per posedge: rst > flush_w > stall_w > capture.
//     - rst: valid_w=0 and all W registers=0; instret=0.
//     - flush_w (stall_w ignored): valid_w=0; other fields don't-care, zeroed.
//     - stall_w: all W registers hold.
//     - else: capture all *_m inputs into *_w.
//   - Reset values: AD3=0, WD3=0, WE3=0, instret=0; rd1_d/rd2_d pass rf data through.
//   - Latency: MEM values appear on the W outputs 1 cycle after capture; register file write occurs at the following edge.
//   - WE3 = valid_w & reg_write_w & (rd_w!=0). AD3 = rd_w. Outputs are combinational from W registers.
//   - Load extraction uses offset alu_result_w[1:0]:
//     - byte: selects bits [8*off+7 : 8*off].
//     - half: selects the upper half if off[1]=1, else the lower half; off[0] is ignored (misalignment is not trapped).
//     - word: whole word; offset ignored.
//     - LB/LH sign-extend; LBU/LHU zero-extend.
//     - Undefined funct3 values are treated as LW.
//   - WD3 mux: ALU -> alu_result_w; load -> extended data; PC+4 -> pc_plus4_w; 11 -> alu_result_w.
//   - Bypass: rd1_d = (WE3 && rs1_d==AD3) ? WD3 : rf_rd1. rd2_d is identical using rs2_d/rf_rd2.
//     - No bypass occurs for x0, since WE3 is 0 when rd_w=0.
//   - Retire: retire = valid_w & ~stall_w; instret += retire at each posedge.
//     - A stalled instruction is counted once, on its final WB cycle.
//     - Writes repeated during a stall are idempotent.
//     - instret wraps from all-ones to 0.
//   - A flush together with a retire in the same cycle still counts the retiring instruction.
//   - rst asserted mid-stall clears everything in the same edge; WE3 is 0 in the next cycle.
// STRUCTURE
//   - Shared package riscv_pkg holds:
//     - result_src_t enum {RES_ALU, RES_LOAD, RES_PC4}.
//     - Load funct3 constants F3_LB..F3_LHU.
//     - Width localparams.
//   - Sub-module load_extend (combinational: word, offset, funct3 -> 32-bit value), instantiated once on W registers.
//   - Top level contains the W register bank, result mux, bypass comparators and instret counter.
// TESTING
//   - Reset then idle: rst 2 cycles -> WE3=0, WD3=0, instret=0; rf_rd1=0x1234 passes to rd1_d.
//   - ALU write: valid_m=1, reg_write_m=1, rd_m=5, src=00, alu=0xDEADBEEF -> next cycle AD3=5, WD3=0xDEADBEEF, WE3=1; instret=1 one cycle later.
//   - Loads on read_data_m=0x80FF7F01:
//     - LB at offset 3 -> WD3=0xFFFFFF80.
//     - LBU at offset 1 -> WD3=0x0000007F.
//     - LH at offset 2 -> WD3=0xFFFF80FF.
//     - LHU at offset 0 -> WD3=0x00007F01.
//   - Bypass: W holds rd=7, data=0x55; rs1_d=7, rf_rd1=0x11 -> rd1_d=0x55. With rd=0, or reg_write=0, -> rd1_d=0x11.
//   - Stall/flush:
//     - stall_w held 3 cycles with a valid W instruction -> AD3/WD3 stable and instret +1 total.
//     - flush_w -> WE3=0 next cycle.
//     - flush_w+stall_w together -> bubble captured.
//   - Wrap: preload instret to all-ones via a force/backdoor, retire 1 instruction -> instret=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined core: widths, writeback source encoding, load funct3 codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int INSTRET_W = 64;

    // Writeback result source; the unused code 2'b11 falls back to the ALU path.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    // Load size/sign encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Extracts a byte/half/word from an aligned memory word and sign/zero extends it to 32 bits.
// Latency: combinational.
// Backpressure: none.
// Ports: i_word (raw aligned word), i_offset (byte offset within word), i_funct3 (load kind),
//        o_value (extended load result).
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Misaligned halfword accesses are not trapped: offset bit 0 is simply dropped.
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_value = i_word;
        case (i_funct3)
            F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_value = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_value = {24'd0, w_byte};
            F3_LHU:  o_value = {16'd0, w_half};
            // LW and every undefined encoding return the full word.
            default: o_value = i_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, load extension, writeback mux, WB->ID bypass and instret counter.
// Latency: MEM inputs appear on AD3/WD3/WE3 one cycle after capture; the register file writes on the next edge.
// Backpressure: stall_w holds the W registers and suppresses retirement; flush_w captures a bubble.
// Ports: clk/rst (sync active-high); stall_w/flush_w pipeline control; *_m MEM-stage inputs;
//        AD3/WD3/WE3 register file write port; rs*_d/rf_rd* ID read indices and raw data;
//        rd1_d/rd2_d bypassed ID operands; instret retired-instruction count.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int INSTRET_WIDTH = INSTRET_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_w,
    input  logic                     flush_w,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [ADDRESS_WIDTH-1:0] rd_m,
    input  logic [1:0]               result_src_m,
    input  logic [2:0]               funct3_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    input  logic [DATA_WIDTH-1:0]    pc_plus4_m,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic                     WE3,
    input  logic [ADDRESS_WIDTH-1:0] rs1_d,
    input  logic [ADDRESS_WIDTH-1:0] rs2_d,
    input  logic [DATA_WIDTH-1:0]    rf_rd1,
    input  logic [DATA_WIDTH-1:0]    rf_rd2,
    output logic [DATA_WIDTH-1:0]    rd1_d,
    output logic [DATA_WIDTH-1:0]    rd2_d,
    output logic [INSTRET_WIDTH-1:0] instret
);

    // W-stage register bank
    logic                     r_valid_w;
    logic                     r_reg_write_w;
    logic [ADDRESS_WIDTH-1:0] r_rd_w;
    logic [1:0]               r_result_src_w;
    logic [2:0]               r_funct3_w;
    logic [DATA_WIDTH-1:0]    r_alu_result_w;
    logic [DATA_WIDTH-1:0]    r_read_data_w;
    logic [DATA_WIDTH-1:0]    r_pc_plus4_w;
    logic [INSTRET_WIDTH-1:0] r_instret;

    logic [DATA_WIDTH-1:0]    w_load_val;
    logic [DATA_WIDTH-1:0]    w_wd;
    logic                     w_we;
    logic                     w_retire;

    // Reset and flush both leave a zeroed bubble; a flush overrides a simultaneous stall.
    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            r_valid_w      <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_rd_w         <= '0;
            r_result_src_w <= 2'b00;
            r_funct3_w     <= 3'b000;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
            r_pc_plus4_w   <= '0;
        end else if (!stall_w) begin
            r_valid_w      <= valid_m;
            r_reg_write_w  <= reg_write_m;
            r_rd_w         <= rd_m;
            r_result_src_w <= result_src_m;
            r_funct3_w     <= funct3_m;
            r_alu_result_w <= alu_result_m;
            r_read_data_w  <= read_data_m;
            r_pc_plus4_w   <= pc_plus4_m;
        end
    end

    // An instruction retires only on its last WB cycle, so a stalled one is counted once.
    // A flush does not block retirement of the instruction currently leaving WB.
    assign w_retire = r_valid_w & ~stall_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    load_extend u_load_extend (
        .i_word   (r_read_data_w),
        .i_offset (r_alu_result_w[1:0]),
        .i_funct3 (r_funct3_w),
        .o_value  (w_load_val)
    );

    always_comb begin
        w_wd = r_alu_result_w;
        case (r_result_src_w)
            RES_LOAD: w_wd = w_load_val;
            RES_PC4:  w_wd = r_pc_plus4_w;
            default:  w_wd = r_alu_result_w;
        endcase
    end

    // x0 is never written, which also keeps x0 out of the bypass path below.
    assign w_we = r_valid_w & r_reg_write_w & (r_rd_w != '0);

    assign AD3     = r_rd_w;
    assign WD3     = w_wd;
    assign WE3     = w_we;
    assign instret = r_instret;

    // The register file writes on the edge but reads asynchronously, so ID would see
    // stale data in the cycle the write is pending; forward WD3 instead.
    assign rd1_d = (w_we && (rs1_d == r_rd_w)) ? w_wd : rf_rd1;
    assign rd2_d = (w_we && (rs2_d == r_rd_w)) ? w_wd : rf_rd2;

endmodule
